// File: rtl/fft_host_sequencer.sv
// fft_host_sequencer: loads one complex frame into the FFT core, runs the transform, and streams the result bins back out
module fft_host_sequencer #(
  parameter int unsigned N_POINTS     = 64,
  parameter int unsigned ARM_TIMEOUT  = 15,
  parameter int unsigned DONE_TIMEOUT = 4095
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [7:0]                  s_re_i,
  input  logic [7:0]                  s_im_i,
  output logic [2:0]                  core_cmd_o,
  output logic [$clog2(N_POINTS)-1:0] core_addr_o,
  output logic                        core_sel_o,
  output logic [7:0]                  core_wdata_o,
  input  logic [7:0]                  core_rdata_i,
  input  logic                        core_busy_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [7:0]                  m_re_o,
  output logic [7:0]                  m_im_o,
  output logic [$clog2(N_POINTS)-1:0] m_idx_o,
  output logic                        active_o,
  output logic                        done_o,
  output logic                        err_o
);
  localparam int unsigned AW = $clog2(N_POINTS);
  localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);
  localparam logic [2:0] CMD_IDLE = 3'b000, CMD_WR = 3'b001, CMD_FFT = 3'b010, CMD_RD = 3'b011;
  typedef enum logic [3:0] {
    IDLE, LD_ENTER, LD_WAIT, WR_RE, WR_IM, LD_EXIT, GO, ARM, RUN,
    RD_ENTER, RD_RE, RD_IM, RD_CAP, EMIT, FIN
  } state_t;
  state_t state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d, i_q, i_d, j_q, j_d, m_idx_q, m_idx_d;
  logic sel_q, sel_d, m_valid_q, m_valid_d, err_q, err_d;
  logic [7:0] wdata_q, wdata_d, im_q, im_d, m_re_q, m_re_d, m_im_q, m_im_d;
  logic [TW-1:0] tmr_q, tmr_d;
  assign s_ready_o    = state_q == LD_WAIT;
  assign active_o     = state_q != IDLE;
  assign done_o       = state_q == FIN;
  assign err_o        = err_q;
  assign core_cmd_o   = cmd_q;
  assign core_addr_o  = addr_q;
  assign core_sel_o   = sel_q;
  assign core_wdata_o = wdata_q;
  assign m_valid_o    = m_valid_q;
  assign m_re_o       = m_re_q;
  assign m_im_o       = m_im_q;
  assign m_idx_o      = m_idx_q;
  // State and every core/stream output register; reset drops the core command to idle at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_IDLE;
      addr_q    <= '0;
      sel_q     <= 1'b0;
      wdata_q   <= '0;
      im_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      tmr_q     <= '0;
      m_valid_q <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_idx_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      im_q      <= im_d;
      i_q       <= i_d;
      j_q       <= j_d;
      tmr_q     <= tmr_d;
      m_valid_q <= m_valid_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      m_idx_q   <= m_idx_d;
      err_q     <= err_d;
    end
  end
  // Next state plus the output values the next state presents to the core and the result stream
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    im_d      = im_q;
    i_d       = i_q;
    j_d       = j_q;
    tmr_d     = tmr_q;
    m_valid_d = m_valid_q;
    m_re_d    = m_re_q;
    m_im_d    = m_im_q;
    m_idx_d   = m_idx_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LD_ENTER;
        cmd_d   = CMD_WR;
        addr_d  = '0;
        sel_d   = 1'b0;
        wdata_d = '0;
        i_d     = '0;
        j_d     = '0;
        err_d   = 1'b0;
      end
      LD_ENTER: state_d = LD_WAIT;
      LD_WAIT: if (s_valid_i) begin
        state_d = WR_RE;
        addr_d  = i_q;
        sel_d   = 1'b0;
        wdata_d = s_re_i;
        im_d    = s_im_i;
      end
      WR_RE: begin
        state_d = WR_IM;
        sel_d   = 1'b1;
        wdata_d = im_q;
      end
      WR_IM: begin
        i_d     = i_q + 1'b1;
        state_d = i_q == LAST ? LD_EXIT : LD_WAIT;
        cmd_d   = i_q == LAST ? CMD_IDLE : CMD_WR;
      end
      LD_EXIT: begin
        state_d = GO;
        cmd_d   = CMD_FFT;
      end
      GO: begin
        state_d = ARM;
        cmd_d   = CMD_IDLE;
        tmr_d   = '0;
      end
      ARM: begin
        tmr_d = core_busy_i ? '0 : tmr_q + 1'b1;
        if (core_busy_i) state_d = RUN;
        else if (tmr_q == TW'(ARM_TIMEOUT - 1)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end
      end
      RUN: begin
        tmr_d = tmr_q + 1'b1;
        if (!core_busy_i) begin
          state_d = RD_ENTER;
          cmd_d   = CMD_RD;
        end else if (tmr_q == TW'(DONE_TIMEOUT - 1)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end
      end
      RD_ENTER: begin
        state_d = RD_RE;
        addr_d  = j_q;
        sel_d   = 1'b0;
      end
      RD_RE: begin
        state_d = RD_IM;
        sel_d   = 1'b1;
      end
      RD_IM: begin
        state_d = RD_CAP;
        m_re_d  = core_rdata_i;
      end
      RD_CAP: begin
        state_d   = EMIT;
        m_im_d    = core_rdata_i;
        m_idx_d   = j_q;
        m_valid_d = 1'b1;
      end
      EMIT: if (m_ready_i) begin
        m_valid_d = 1'b0;
        j_d       = j_q + 1'b1;
        addr_d    = j_q + 1'b1;
        sel_d     = 1'b0;
        state_d   = j_q == LAST ? FIN : RD_RE;
        cmd_d     = j_q == LAST ? CMD_IDLE : CMD_RD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fft_host_sequencer.sv
// tb_fft_host_sequencer: drives frames through the sequencer against a behavioural identity-transform core
module tb_fft_host_sequencer;
  localparam int AT = 15;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0] s_re = '0, s_im = '0, rdata = '0;
  logic s_ready, sel, busy, m_valid, active, done, err;
  logic [2:0] cmd;
  logic [5:0] addr, m_idx;
  logic [7:0] wdata, m_re, m_im;
  logic [7:0] mem_re [64];
  logic [7:0] mem_im [64];
  logic [63:0] wre, wim;
  logic clr = 1'b0;
  int bcnt = 0, blen = 10;
  bit bnever = 1'b0;
  int n_vec = 0, n_bad = 0;

  fft_host_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_re_i(s_re), .s_im_i(s_im), .core_cmd_o(cmd), .core_addr_o(addr), .core_sel_o(sel),
    .core_wdata_o(wdata), .core_rdata_i(rdata), .core_busy_i(busy), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_re_o(m_re), .m_im_o(m_im), .m_idx_o(m_idx), .active_o(active),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  assign busy = bcnt != 0;

  // Model core: writes on data-input command, 1-cycle registered reads, busy for blen cycles after FFT command
  always @(posedge clk) begin
    if (clr) begin
      wre <= '0;
      wim <= '0;
    end else if (cmd == 3'b001) begin
      if (sel) begin
        mem_im[addr] <= wdata;
        wim[addr] <= 1'b1;
      end else begin
        mem_re[addr] <= wdata;
        wre[addr] <= 1'b1;
      end
    end
    if (cmd == 3'b011) rdata <= sel ? mem_im[addr] : mem_re[addr];
    if (cmd == 3'b010 && !bnever) bcnt <= blen;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_cmd", cmd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_sel", sel, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_im", m_im, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  // One frame: the reference is the accepted-sample list; the identity core must hand it back bin for bin
  task automatic run_frame(input bit ramp, input int vpct, input int rpct, input int stall_bin,
                           input bit noise, input bit exp_err, input int exp_cyc, input bit abort);
    logic [7:0] er [64];
    logic [7:0] ei [64];
    logic [7:0] hre, him;
    int acc, kout, ngo, nfin, bseen, stall, bad;
    bit pacc, dn;
    acc = 0; kout = 0; ngo = 0; nfin = 0; bseen = 0; stall = 0; bad = 0;
    pacc = 1'b0; dn = 1'b0; hre = '0; him = '0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 20000 && !dn; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("err_clear_on_start", err, 0);
        chk("active_in_load", active, 1);
      end
      if (cmd == 3'b010 && ngo == 0) ngo = n;
      if (abort && busy && ngo != 0) begin
        bseen++;
        if (bseen == 3) return;
      end
      s_valid = int'($urandom_range(99)) < vpct;
      s_re = ramp ? 8'(acc) : 8'($urandom);
      s_im = ramp ? 8'(-acc) : 8'($urandom);
      if (pacc) chk("s_ready_gap", s_ready, 0);
      pacc = s_ready && s_valid;
      if (pacc) begin
        if (acc < 64) begin
          er[acc] = s_re;
          ei[acc] = s_im;
        end
        acc++;
      end
      if (stall_bin >= 0 && m_valid && m_idx == 6'(stall_bin) && stall < 20) begin
        if (stall == 0) begin
          hre = m_re;
          him = m_im;
        end else begin
          chk("stall_idx", m_idx, stall_bin);
          chk("stall_re", m_re, hre);
          chk("stall_im", m_im, him);
          chk("stall_cmd", cmd, 3);
        end
        stall++;
        m_ready = 1'b0;
      end else m_ready = int'($urandom_range(99)) < rpct;
      if (m_valid && m_ready) begin
        chk("bin_in_range", kout < 64, 1);
        if (kout < 64) begin
          chk("m_idx", m_idx, kout);
          chk("m_re", m_re, er[kout]);
          chk("m_im", m_im, ei[kout]);
        end
        kout++;
      end
      if (done) begin
        dn = 1'b1;
        nfin = n;
        chk("err_at_done", err, exp_err);
      end
      start = noise && active && ($urandom_range(3) == 0);
    end
    start = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("done_seen", dn, 1);
    if (exp_cyc != 0) chk("frame_cycles", nfin, exp_cyc);
    if (exp_err) chk("arm_timeout_after_go", nfin - ngo, AT + 1);
    chk("samples_accepted", acc, 64);
    chk("bins_emitted", kout, exp_err ? 0 : 64);
    chk("re_all_written", &wre, 1);
    chk("im_all_written", &wim, 1);
    for (int i = 0; i < 64; i++) if (mem_re[i] !== er[i] || mem_im[i] !== ei[i]) bad++;
    chk("core_mem_contents", bad, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_fin", active, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    run_frame(1'b1, 100, 100, -1, 1'b0, 1'b0, 464, 1'b0);
    run_frame(1'b0, 50, 100, -1, 1'b0, 1'b0, 0, 1'b0);
    run_frame(1'b0, 100, 100, 5, 1'b0, 1'b0, 484, 1'b0);
    blen = 30;
    run_frame(1'b0, 60, 70, -1, 1'b1, 1'b0, 0, 1'b0);
    bnever = 1'b1;
    run_frame(1'b0, 100, 100, -1, 1'b0, 1'b1, 211, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky_in_idle", err, 1);
    bnever = 1'b0;
    blen = 10;
    run_frame(1'b1, 100, 100, -1, 1'b0, 1'b0, 464, 1'b1);
    chk("abort_in_run", cmd, 0);
    rst_n = 1'b0;
    #1;
    chk_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_done_in_reset", done, 0);
    end
    rst_n = 1'b1;
    run_frame(1'b1, 100, 100, -1, 1'b0, 1'b0, 464, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
